// File: rtl/switch_debouncer_if.sv
// Switch debouncer bus: raw switch levels in, debounced word and change masks out.
interface switch_debouncer_if #(
  parameter int unsigned NUM_SW = 10
);

  logic [NUM_SW-1:0] i_sw;
  logic [31:0]       o_sw_data;
  logic              o_sw_changed;
  logic [31:0]       o_sw_rise;
  logic [31:0]       o_sw_fall;

  // Board / stimulus side: drives raw levels, observes conditioned outputs
  modport master (
    output i_sw,
    input  o_sw_data,
    input  o_sw_changed,
    input  o_sw_rise,
    input  o_sw_fall
  );

  // Debouncer side
  modport slave (
    input  i_sw,
    output o_sw_data,
    output o_sw_changed,
    output o_sw_rise,
    output o_sw_fall
  );

endinterface

// File: rtl/switch_debouncer.sv
// Per-switch 2-FF synchroniser plus stability counter; publishes a clean 32-bit
// switch word and one-cycle change pulse with rise/fall masks.
module switch_debouncer #(
  parameter int unsigned NUM_SW          = 10,
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic              i_clk,
  input  logic              i_reset,
  switch_debouncer_if.slave sw_if
);

  localparam int unsigned     CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Reject illegal configurations at elaboration
  if (NUM_SW < 1 || NUM_SW > 32) begin : g_bad_num_sw
    $error("switch_debouncer: NUM_SW must be in 1..32");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_cycles
    $error("switch_debouncer: DEBOUNCE_CYCLES must be >= 1");
  end

  logic [NUM_SW-1:0] sync1_q;
  logic [NUM_SW-1:0] sync2_q;
  logic [NUM_SW-1:0] stable_q;
  logic [NUM_SW-1:0] stable_d;
  logic [CNT_W-1:0]  cnt_q [NUM_SW];
  logic [CNT_W-1:0]  cnt_d [NUM_SW];
  logic [NUM_SW-1:0] upd_c;
  logic              changed_q;
  logic              changed_d;
  logic [NUM_SW-1:0] rise_q;
  logic [NUM_SW-1:0] rise_d;
  logic [NUM_SW-1:0] fall_q;
  logic [NUM_SW-1:0] fall_d;

  // Stability counters: any cycle matching the accepted level restarts the count
  always_comb begin
    stable_d = stable_q;
    upd_c    = '0;
    for (int i = 0; i < int'(NUM_SW); i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          stable_d[i] = sync2_q[i];
          upd_c[i]    = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
    rise_d    = upd_c & sync2_q;
    fall_d    = upd_c & ~sync2_q;
    changed_d = |upd_c;
  end

  // State registers; reset discards any partial qualification immediately
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      stable_q  <= '0;
      changed_q <= 1'b0;
      rise_q    <= '0;
      fall_q    <= '0;
      for (int i = 0; i < int'(NUM_SW); i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q   <= sw_if.i_sw;
      sync2_q   <= sync1_q;
      stable_q  <= stable_d;
      changed_q <= changed_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      for (int i = 0; i < int'(NUM_SW); i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // Zero-extend to the fixed 32-bit bus
  assign sw_if.o_sw_data    = 32'(stable_q);
  assign sw_if.o_sw_changed = changed_q;
  assign sw_if.o_sw_rise    = 32'(rise_q);
  assign sw_if.o_sw_fall    = 32'(fall_q);

endmodule

// File: tb/tb_switch_debouncer.sv
// Directed and randomised checks of switch_debouncer with NUM_SW=10, D=4.
module tb_switch_debouncer;

  localparam int unsigned NSW = 10;
  localparam int unsigned DEB = 4;

  logic i_clk;
  logic i_reset;

  switch_debouncer_if #(.NUM_SW(NSW)) sw_if ();

  switch_debouncer #(
    .NUM_SW          (NSW),
    .DEBOUNCE_CYCLES (DEB)
  ) dut (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .sw_if   (sw_if)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state for the random phase
  logic [NSW-1:0] m_s1;
  logic [NSW-1:0] m_s2;
  logic [NSW-1:0] m_stable;
  logic [NSW-1:0] m_chg;
  int             m_run [NSW];

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic check_outs(input string tag, input logic [31:0] data, input logic chg,
                            input logic [31:0] rise, input logic [31:0] fall);
    chk({tag, "_data"}, sw_if.o_sw_data, data);
    chk({tag, "_chg"},  32'(sw_if.o_sw_changed), 32'(chg));
    chk({tag, "_rise"}, sw_if.o_sw_rise, rise);
    chk({tag, "_fall"}, sw_if.o_sw_fall, fall);
  endtask

  // Model: a new level is accepted after DEB consecutive edges of disagreement
  task automatic model_step(input logic [NSW-1:0] x);
    m_chg = '0;
    for (int i = 0; i < int'(NSW); i++) begin
      if (m_s2[i] !== m_stable[i]) begin
        m_run[i] = m_run[i] + 1;
        if (m_run[i] == int'(DEB)) begin
          m_stable[i] = m_s2[i];
          m_run[i]    = 0;
          m_chg[i]    = 1'b1;
        end
      end else begin
        m_run[i] = 0;
      end
    end
    m_s2 = m_s1;
    m_s1 = x;
  endtask

  initial begin
    logic [NSW-1:0] x;
    logic [31:0]    prev_data;

    i_reset   = 1'b1;
    sw_if.i_sw = '0;
    tick();
    tick();
    check_outs("rst_init", 32'h0, 1'b0, 32'h0, 32'h0);
    i_reset = 1'b0;

    // 1: all switches high, then asynchronous reset mid-cycle and re-qualify
    sw_if.i_sw = 10'h3FF;
    repeat (10) tick();
    chk("t1_pre_data", sw_if.o_sw_data, 32'h3FF);
    #2;
    i_reset = 1'b1;
    #1;
    check_outs("t1_async", 32'h0, 1'b0, 32'h0, 32'h0);
    tick();
    check_outs("t1_held", 32'h0, 1'b0, 32'h0, 32'h0);
    i_reset = 1'b0;
    for (int e = 1; e <= 5; e++) begin
      tick();
      check_outs($sformatf("t1_e%0d", e), 32'h0, 1'b0, 32'h0, 32'h0);
    end
    tick();
    check_outs("t1_e6", 32'h3FF, 1'b1, 32'h3FF, 32'h0);
    tick();
    check_outs("t1_e7", 32'h3FF, 1'b0, 32'h0, 32'h0);

    // 2: single rise from all-zero
    sw_if.i_sw = '0;
    repeat (10) tick();
    chk("t2_zero", sw_if.o_sw_data, 32'h0);
    sw_if.i_sw = 10'h001;
    for (int e = 1; e <= 5; e++) begin
      tick();
      check_outs($sformatf("t2_e%0d", e), 32'h0, 1'b0, 32'h0, 32'h0);
    end
    tick();
    check_outs("t2_e6", 32'h1, 1'b1, 32'h1, 32'h0);
    tick();
    check_outs("t2_e7", 32'h1, 1'b0, 32'h0, 32'h0);

    // 3: bouncing bit 3 never qualifies
    for (int r = 0; r < 10; r++) begin
      sw_if.i_sw = 10'h009;
      repeat (3) begin
        tick();
        check_outs("t3_hi", 32'h1, 1'b0, 32'h0, 32'h0);
      end
      sw_if.i_sw = 10'h001;
      tick();
      check_outs("t3_lo", 32'h1, 1'b0, 32'h0, 32'h0);
    end
    repeat (8) begin
      tick();
      check_outs("t3_tail", 32'h1, 1'b0, 32'h0, 32'h0);
    end

    // 4: simultaneous rise and fall of bits 1 and 9
    sw_if.i_sw = '0;
    repeat (10) tick();
    chk("t4_zero", sw_if.o_sw_data, 32'h0);
    sw_if.i_sw = 10'h202;
    repeat (5) begin
      tick();
      check_outs("t4_wait_r", 32'h0, 1'b0, 32'h0, 32'h0);
    end
    tick();
    check_outs("t4_rise", 32'h202, 1'b1, 32'h202, 32'h0);
    tick();
    check_outs("t4_rise_end", 32'h202, 1'b0, 32'h0, 32'h0);
    sw_if.i_sw = '0;
    repeat (5) begin
      tick();
      check_outs("t4_wait_f", 32'h202, 1'b0, 32'h0, 32'h0);
    end
    tick();
    check_outs("t4_fall", 32'h0, 1'b1, 32'h0, 32'h202);
    tick();
    check_outs("t4_fall_end", 32'h0, 1'b0, 32'h0, 32'h0);

    // 5: reset mid-count discards progress
    sw_if.i_sw = 10'h020;
    repeat (3) begin
      tick();
      check_outs("t5_pre", 32'h0, 1'b0, 32'h0, 32'h0);
    end
    i_reset = 1'b1;
    #1;
    check_outs("t5_rst", 32'h0, 1'b0, 32'h0, 32'h0);
    tick();
    i_reset = 1'b0;
    for (int e = 1; e <= 5; e++) begin
      tick();
      check_outs($sformatf("t5_e%0d", e), 32'h0, 1'b0, 32'h0, 32'h0);
    end
    tick();
    check_outs("t5_e6", 32'h20, 1'b1, 32'h20, 32'h0);

    // 6: random stimulus against the model
    i_reset    = 1'b1;
    sw_if.i_sw = '0;
    tick();
    i_reset = 1'b0;
    m_s1     = '0;
    m_s2     = '0;
    m_stable = '0;
    m_chg    = '0;
    for (int i = 0; i < int'(NSW); i++) m_run[i] = 0;
    x         = '0;
    prev_data = 32'h0;
    for (int c = 0; c < 10000; c++) begin
      for (int i = 0; i < int'(NSW); i++) begin
        if ($urandom_range(0, 7) == 0) x[i] = ~x[i];
      end
      sw_if.i_sw = x;
      tick();
      model_step(x);
      check_outs("rnd", 32'(m_stable), |m_chg, 32'(m_chg & m_stable), 32'(m_chg & ~m_stable));
      chk("rnd_edge_vs_pulse", 32'(sw_if.o_sw_data != prev_data), 32'(sw_if.o_sw_changed));
      prev_data = sw_if.o_sw_data;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
